// File: rtl/relational_comparator.sv
// relational_comparator: registered eq/gt/lt compare with derived ge/le/ne flags.
// Define COMP_SIGNED_EN to add the sgn port for per-request two's-complement compares.
module relational_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef COMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  output logic             AeqB,
  output logic             AmaB,
  output logic             AmeB,
  output logic             AgeB,
  output logic             AleB,
  output logic             AneB
);
  logic       signed_mode, eq, gt, valid_q;
  logic [5:0] flags_d, flags_q;
`ifdef COMP_SIGNED_EN
  assign signed_mode = sgn;
`else
  assign signed_mode = 1'b0;
`endif
  // With differing MSBs the MSB alone decides; signed mode inverts which side wins.
  always_comb begin
    eq = A == B;
    gt = (A[WIDTH-1] != B[WIDTH-1]) ? (signed_mode ? B[WIDTH-1] : A[WIDTH-1])
                                    : (A[WIDTH-2:0] > B[WIDTH-2:0]);
    flags_d = in_valid ? {eq, gt, ~eq & ~gt, gt | eq, ~gt, ~eq} : flags_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      valid_q <= in_valid;
    end
  end
  assign {AeqB, AmaB, AmeB, AgeB, AleB, AneB} = flags_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_relational_comparator.sv
// tb_relational_comparator: random and directed checks of 8- and 32-bit comparators against an arithmetic model.
module tb_relational_comparator;
`ifdef COMP_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sgn = 1'b0;
  logic [7:0]  A8 = '0, B8 = '0;
  logic [31:0] A32 = '0, B32 = '0;
  logic [5:0]  f8, f32, e8 = '0, e32 = '0;
  logic        ov8, ov32, ev = 1'b0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  relational_comparator #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A8), .B(B8),
`ifdef COMP_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(ov8), .AeqB(f8[5]), .AmaB(f8[4]), .AmeB(f8[3]),
    .AgeB(f8[2]), .AleB(f8[1]), .AneB(f8[0]));

  relational_comparator #(.WIDTH(32)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A32), .B(B32),
`ifdef COMP_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(ov32), .AeqB(f32[5]), .AmaB(f32[4]), .AmeB(f32[3]),
    .AgeB(f32[2]), .AleB(f32[1]), .AneB(f32[0]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operands become integers (negative when signed and MSB set), then compared arithmetically.
  function automatic logic [5:0] model(input logic [31:0] a, input logic [31:0] b, input logic s, input int w);
    logic [31:0] m;
    longint va, vb;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    va = longint'({32'b0, a & m});
    vb = longint'({32'b0, b & m});
    if (s && a[w-1]) va = va - (64'sd1 <<< w);
    if (s && b[w-1]) vb = vb - (64'sd1 <<< w);
    return {va == vb, va > vb, va < vb, va >= vb, va <= vb, va != vb};
  endfunction

  task automatic verify();
    check("flags8", 32'(f8), 32'(e8));
    check("valid8", 32'(ov8), 32'(ev));
    check("flags32", 32'(f32), 32'(e32));
    check("valid32", 32'(ov32), 32'(ev));
    if (ev) begin
      check("onehot8", $countones(f8[5:3]), 1);
      check("onehot32", $countones(f32[5:3]), 1);
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
    @(negedge clk);
    rst = 1'b0;
    A8 = a; B8 = b; sgn = s; in_valid = v;
    A32 = $urandom; B32 = $urandom;
    if ($urandom_range(3) == 0) B32 = A32;
    else if ($urandom_range(3) == 0) B32 = A32 ^ 32'h8000_0000;
    if (v) begin
      e8 = model({24'b0, a}, {24'b0, b}, s & SE, 8);
      e32 = model(A32, B32, s & SE, 32);
    end
    ev = v;
    @(posedge clk);
    #1;
    verify();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    e8 = '0; e32 = '0; ev = 1'b0;
    verify();
  endtask

  initial begin
    #1 verify();
    step(8'h33, 8'h22, 1'b0, 1'b0);
    step(8'h0D, 8'h0D, 1'b0, 1'b1);
    step(8'hFF, 8'hFF, 1'b0, 1'b1);
    step(8'h10, 8'h0F, 1'b0, 1'b1);
    step(8'h0E, 8'h11, 1'b0, 1'b1);
    step(8'hF0, 8'h0F, 1'b0, 1'b1);
    step(8'h01, 8'hFF, 1'b0, 1'b1);
    step(8'hAA, 8'h55, 1'b0, 1'b1);
    step(8'h55, 8'hAA, 1'b0, 1'b1);
    step(8'hF0, 8'h0F, 1'b1, 1'b1);
    step(8'h01, 8'hFF, 1'b1, 1'b1);
    step(8'h80, 8'h7F, 1'b1, 1'b1);
    step(8'hFF, 8'hFE, 1'b1, 1'b1);
    step(8'h7F, 8'h80, 1'b1, 1'b1);
    step(8'h00, 8'h00, 1'b1, 1'b1);
    step(8'h12, 8'h34, 1'b0, 1'b0);
    step(8'hEE, 8'h01, 1'b1, 1'b0);
    async_reset();
    step(8'h44, 8'h44, 1'b0, 1'b0);
    step(8'h44, 8'h43, 1'b0, 1'b1);
    async_reset();
    step(8'h02, 8'h90, 1'b1, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(4) == 0) ? a : 8'($urandom);
      step(a, b, 1'($urandom), $urandom_range(7) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
